// File: rtl/pipeline_mem_sys.sv
// pipeline_mem_sys
//
// Memory-side responder for the pipelined core. It holds the instruction and
// data memories, answers the core's fetch/load/store requests, gives a host a
// load/dump port while the core is halted, and keeps access counters.
//
// Ports
//   clk, rst_n             clock, synchronous active-low reset
//   I_ADDR, im_oen, IR     core fetch port (combinational read, im_oen active low)
//   D_ADDR, D_OUT, D_IN    core data port (synchronous, one cycle load latency)
//   dm_oen, dm_wen         load / store enables, active low
//   cpu_rst_n              reset to the core, low while the host owns memory
//   run_req, running       host run request / core-running indication
//   h_valid, h_ready       host request handshake (ready only while halted)
//   h_we, h_sel, h_addr    host write flag, space select, word address
//   h_wdata                host write data
//   h_rvalid, h_rdata      host read return, one cycle after acceptance
//
// Host spaces (h_sel): 00 imem, 01 dmem, 10 counters, 11 reserved.
// Counter space (h_addr[1:0]): 0 fetches, 1 loads, 2 stores, 3 RUN cycles.
//
// Depths are expected to be powers of two no larger than 2**AW; addresses
// are truncated to the memory index width, which gives the modulo wrap.

module pipeline_mem_sys #(
  parameter int AW        = 11,
  parameter int DW        = 32,
  parameter int IDEPTH    = 2048,
  parameter int DDEPTH    = 2048,
  parameter int DRAIN_CYC = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] I_ADDR,
  input  logic          im_oen,
  output logic [DW-1:0] IR,
  input  logic [AW-1:0] D_ADDR,
  input  logic [DW-1:0] D_OUT,
  input  logic          dm_oen,
  input  logic          dm_wen,
  output logic [DW-1:0] D_IN,
  output logic          cpu_rst_n,
  input  logic          run_req,
  output logic          running,
  input  logic          h_valid,
  output logic          h_ready,
  input  logic          h_we,
  input  logic [1:0]    h_sel,
  input  logic [AW-1:0] h_addr,
  input  logic [DW-1:0] h_wdata,
  output logic          h_rvalid,
  output logic [DW-1:0] h_rdata
);

  localparam int IAW = $clog2(IDEPTH);
  localparam int DAW = $clog2(DDEPTH);
  localparam int DCW = (DRAIN_CYC < 2) ? 1 : $clog2(DRAIN_CYC + 1);

  localparam logic [1:0] SEL_IMEM = 2'b00;
  localparam logic [1:0] SEL_DMEM = 2'b01;
  localparam logic [1:0] SEL_CNT  = 2'b10;

  typedef enum logic [1:0] {
    HALT  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } stateT;

  stateT          r_state;
  logic [DCW-1:0] r_drainCnt;
  logic           r_cpuRstN;
  logic           r_running;
  logic           r_hostOwn;

  logic [DW-1:0]  r_imem [IDEPTH];
  logic [DW-1:0]  r_dmem [DDEPTH];

  logic [DW-1:0]  r_dIn;
  logic           r_hRvalid;
  logic [DW-1:0]  r_hRdata;

  logic [31:0]    r_cntFetch;
  logic [31:0]    r_cntLoad;
  logic [31:0]    r_cntStore;
  logic [31:0]    r_cntRun;

  logic           w_coreActive;
  logic           w_coreStore;
  logic           w_coreLoad;
  logic           w_coreFetch;
  logic           w_hostXfer;
  logic           w_hostRead;
  logic           w_hostImemWr;
  logic           w_hostDmemWr;
  logic           w_cntClear;
  logic [DW-1:0]  w_hostRdData;
  logic [IAW-1:0] w_iIdx;
  logic [IAW-1:0] w_hIIdx;
  logic [DAW-1:0] w_dIdx;
  logic [DAW-1:0] w_hDIdx;

  assign w_iIdx  = I_ADDR[IAW-1:0];
  assign w_hIIdx = h_addr[IAW-1:0];
  assign w_dIdx  = D_ADDR[DAW-1:0];
  assign w_hDIdx = h_addr[DAW-1:0];

  // The core is only served outside HALT; in HALT it is held in reset and the
  // host owns both memories, so core and host writes can never collide.
  assign w_coreActive = rst_n && (r_state != HALT);
  assign w_coreStore  = w_coreActive && !dm_wen;
  assign w_coreLoad   = w_coreActive && !dm_oen;
  assign w_coreFetch  = w_coreActive && !im_oen;

  assign w_hostXfer   = h_valid && h_ready;
  assign w_hostRead   = w_hostXfer && !h_we;
  assign w_hostImemWr = w_hostXfer && h_we && (h_sel == SEL_IMEM);
  assign w_hostDmemWr = w_hostXfer && h_we && (h_sel == SEL_DMEM);
  assign w_cntClear   = w_hostXfer && h_we && (h_sel == SEL_CNT);

  // Run-control FSM. Outputs are registered alongside the state so they change
  // together with it. DRAIN keeps the core alive for DRAIN_CYC cycles after
  // run_req drops so in-flight stores land; the count is checked before the
  // decrement, so leaving at 1 gives exactly DRAIN_CYC cycles in DRAIN.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= HALT;
      r_drainCnt <= '0;
      r_cpuRstN  <= 1'b0;
      r_running  <= 1'b0;
      r_hostOwn  <= 1'b1;
    end else begin
      case (r_state)
        HALT: begin
          if (run_req) begin
            r_state   <= RUN;
            r_cpuRstN <= 1'b1;
            r_running <= 1'b1;
            r_hostOwn <= 1'b0;
          end
        end
        RUN: begin
          if (!run_req) begin
            r_state    <= DRAIN;
            r_drainCnt <= DCW'(DRAIN_CYC);
            r_running  <= 1'b0;
          end
        end
        DRAIN: begin
          if (run_req) begin
            r_state   <= RUN;
            r_running <= 1'b1;
          end else if (r_drainCnt <= DCW'(1)) begin
            r_state    <= HALT;
            r_drainCnt <= '0;
            r_cpuRstN  <= 1'b0;
            r_hostOwn  <= 1'b1;
          end else begin
            r_drainCnt <= r_drainCnt - DCW'(1);
          end
        end
        default: begin
          r_state    <= HALT;
          r_drainCnt <= '0;
          r_cpuRstN  <= 1'b0;
          r_running  <= 1'b0;
          r_hostOwn  <= 1'b1;
        end
      endcase
    end
  end

  // Reset and host-ownership outputs also drop combinationally with rst_n so
  // the core and host see the reset in the very cycle it is asserted.
  assign cpu_rst_n = r_cpuRstN && rst_n;
  assign running   = r_running;
  assign h_ready   = r_hostOwn && rst_n;

  // Instruction memory: written only by the host, read combinationally by the
  // core. A halted core must never see a stale instruction, hence the gating.
  always_ff @(posedge clk) begin
    if (w_hostImemWr) begin
      r_imem[w_hIIdx] <= h_wdata;
    end
  end

  assign IR = w_coreFetch ? r_imem[w_iIdx] : '0;

  // Data memory write port, shared between the core (RUN/DRAIN) and the host
  // (HALT). The two sources are mutually exclusive by FSM state.
  always_ff @(posedge clk) begin
    if (w_coreStore) begin
      r_dmem[w_dIdx] <= D_OUT;
    end else if (w_hostDmemWr) begin
      r_dmem[w_hDIdx] <= h_wdata;
    end
  end

  // Load return register. A load and store to the same word in one cycle is
  // write-first, so the store data is forwarded rather than the old word.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_dIn <= '0;
    end else if (!dm_oen) begin
      r_dIn <= w_coreStore ? D_OUT : r_dmem[w_dIdx];
    end
  end

  assign D_IN = r_dIn;

  // Performance counters. Any host write to counter space clears all four;
  // host access only happens in HALT so the clear never races an increment
  // that matters. Counters wrap naturally at 32 bits.
  always_ff @(posedge clk) begin
    if (!rst_n || w_cntClear) begin
      r_cntFetch <= '0;
      r_cntLoad  <= '0;
      r_cntStore <= '0;
      r_cntRun   <= '0;
    end else begin
      if (w_coreFetch) begin
        r_cntFetch <= r_cntFetch + 32'd1;
      end
      if (w_coreLoad) begin
        r_cntLoad <= r_cntLoad + 32'd1;
      end
      if (w_coreStore) begin
        r_cntStore <= r_cntStore + 32'd1;
      end
      if (r_state == RUN) begin
        r_cntRun <= r_cntRun + 32'd1;
      end
    end
  end

  // Host read source select. Counter reads see the register value, i.e. the
  // count before this cycle's increment. The reserved space reads as zero.
  always_comb begin
    w_hostRdData = '0;
    case (h_sel)
      SEL_IMEM: w_hostRdData = r_imem[w_hIIdx];
      SEL_DMEM: w_hostRdData = r_dmem[w_hDIdx];
      SEL_CNT: begin
        case (h_addr[1:0])
          2'd0:    w_hostRdData = DW'(r_cntFetch);
          2'd1:    w_hostRdData = DW'(r_cntLoad);
          2'd2:    w_hostRdData = DW'(r_cntStore);
          default: w_hostRdData = DW'(r_cntRun);
        endcase
      end
      default: w_hostRdData = '0;
    endcase
  end

  // Host read return: one-cycle h_rvalid pulse, data held until the next read.
  // A read in flight when reset arrives is dropped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_hRvalid <= 1'b0;
      r_hRdata  <= '0;
    end else begin
      r_hRvalid <= w_hostRead;
      if (w_hostRead) begin
        r_hRdata <= w_hostRdData;
      end
    end
  end

  assign h_rvalid = r_hRvalid && rst_n;
  assign h_rdata  = r_hRdata;

endmodule

// File: tb/tb_pipeline_mem_sys.sv
// tb_pipeline_mem_sys
//
// Self-checking bench for pipeline_mem_sys. A behavioural model (plain arrays
// and counters, plus the halt/run/drain rules) predicts every output each
// cycle. Inputs are driven on the falling edge and outputs sampled 1 unit
// later, well away from the rising edge.

module tb_pipeline_mem_sys;

  localparam int DRAIN_CYC = 2;
  localparam int M_HALT  = 0;
  localparam int M_RUN   = 1;
  localparam int M_DRAIN = 2;

  logic        clk;
  logic        rst_n;
  logic [10:0] I_ADDR;
  logic        im_oen;
  logic [31:0] IR;
  logic [10:0] D_ADDR;
  logic [31:0] D_OUT;
  logic        dm_oen;
  logic        dm_wen;
  logic [31:0] D_IN;
  logic        cpu_rst_n;
  logic        run_req;
  logic        running;
  logic        h_valid;
  logic        h_ready;
  logic        h_we;
  logic [1:0]  h_sel;
  logic [10:0] h_addr;
  logic [31:0] h_wdata;
  logic        h_rvalid;
  logic [31:0] h_rdata;

  int checks;
  int failures;

  bit          mKnown;
  int          mState;
  int          mDrainLeft;
  logic [31:0] mImem [2048];
  logic [31:0] mDmem [2048];
  logic [31:0] mCnt [4];
  logic [31:0] mDin;
  logic        mHRvalid;
  logic [31:0] mHRdata;

  pipeline_mem_sys #(
    .AW(11), .DW(32), .IDEPTH(2048), .DDEPTH(2048), .DRAIN_CYC(DRAIN_CYC)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .I_ADDR(I_ADDR), .im_oen(im_oen), .IR(IR),
    .D_ADDR(D_ADDR), .D_OUT(D_OUT), .dm_oen(dm_oen), .dm_wen(dm_wen), .D_IN(D_IN),
    .cpu_rst_n(cpu_rst_n), .run_req(run_req), .running(running),
    .h_valid(h_valid), .h_ready(h_ready), .h_we(h_we), .h_sel(h_sel),
    .h_addr(h_addr), .h_wdata(h_wdata), .h_rvalid(h_rvalid), .h_rdata(h_rdata)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Absolute time limit so a stuck run still ends.
  initial begin
    #1000000;
    $display("[TB] FAIL timeout: simulation did not complete, got running expected finished");
    $fatal(1, "[TB] timeout");
  end

  // Single comparison point: counts and reports.
  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] modelHostRead(input logic [1:0] sel, input logic [10:0] addr);
    case (sel)
      2'd0:    return mImem[addr];
      2'd1:    return mDmem[addr];
      2'd2:    return mCnt[addr[1:0]];
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [10:0] pickAddr();
    if ($urandom_range(0, 1) == 0) return 11'($urandom_range(0, 15));
    return 11'($urandom_range(2040, 2047));
  endfunction

  // Runs one cycle with the inputs already staged: compares all outputs with
  // the model, then advances the model by the rising edge.
  task automatic applyStimulus();
    bit active;
    bit xfer;
    #1;
    if (mKnown) begin
      if (!rst_n) begin
        checkOutput("rstHready", 32'(h_ready), 32'd0);
        checkOutput("rstRvalid", 32'(h_rvalid), 32'd0);
        checkOutput("rstCpuRstN", 32'(cpu_rst_n), 32'd0);
        checkOutput("rstIr", IR, 32'd0);
      end else begin
        checkOutput("ir", IR, (mState != M_HALT && im_oen == 1'b0) ? mImem[I_ADDR] : 32'd0);
        checkOutput("hReady", 32'(h_ready), 32'(mState == M_HALT));
        checkOutput("cpuRstN", 32'(cpu_rst_n), 32'(mState != M_HALT));
        checkOutput("running", 32'(running), 32'(mState == M_RUN));
        checkOutput("dIn", D_IN, mDin);
        checkOutput("hRvalid", 32'(h_rvalid), 32'(mHRvalid));
        if (mHRvalid) checkOutput("hRdata", h_rdata, mHRdata);
      end
    end

    if (!rst_n) begin
      mKnown     = 1'b1;
      mState     = M_HALT;
      mDrainLeft = 0;
      mDin       = 32'd0;
      mHRvalid   = 1'b0;
      mHRdata    = 32'd0;
      for (int k = 0; k < 4; k++) mCnt[k] = 32'd0;
    end else begin
      active   = (mState != M_HALT);
      xfer     = h_valid && (mState == M_HALT);
      mHRvalid = xfer && !h_we;
      if (xfer && !h_we) mHRdata = modelHostRead(h_sel, h_addr);
      if (!dm_oen) mDin = (active && !dm_wen) ? D_OUT : mDmem[D_ADDR];
      if (xfer && h_we && h_sel == 2'd2) begin
        for (int k = 0; k < 4; k++) mCnt[k] = 32'd0;
      end else begin
        if (active && !im_oen) mCnt[0] = mCnt[0] + 32'd1;
        if (active && !dm_oen) mCnt[1] = mCnt[1] + 32'd1;
        if (active && !dm_wen) mCnt[2] = mCnt[2] + 32'd1;
        if (mState == M_RUN)   mCnt[3] = mCnt[3] + 32'd1;
      end
      if (active && !dm_wen) mDmem[D_ADDR] = D_OUT;
      if (xfer && h_we && h_sel == 2'd0) mImem[h_addr] = h_wdata;
      if (xfer && h_we && h_sel == 2'd1) mDmem[h_addr] = h_wdata;
      if (mState == M_HALT) begin
        if (run_req) mState = M_RUN;
      end else if (mState == M_RUN) begin
        if (!run_req) begin
          mState     = M_DRAIN;
          mDrainLeft = DRAIN_CYC;
        end
      end else begin
        if (run_req) begin
          mState = M_RUN;
        end else begin
          mDrainLeft = mDrainLeft - 1;
          if (mDrainLeft <= 0) mState = M_HALT;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic idleInputs();
    im_oen  = 1'b1;
    dm_oen  = 1'b1;
    dm_wen  = 1'b1;
    h_valid = 1'b0;
    h_we    = 1'b0;
  endtask

  task automatic hostWrite(input logic [1:0] sel, input logic [10:0] addr, input logic [31:0] data);
    h_valid = 1'b1;
    h_we    = 1'b1;
    h_sel   = sel;
    h_addr  = addr;
    h_wdata = data;
    applyStimulus();
    h_valid = 1'b0;
    h_we    = 1'b0;
  endtask

  task automatic hostRead(input string tag, input logic [1:0] sel, input logic [10:0] addr,
                          input logic [31:0] exp);
    h_valid = 1'b1;
    h_we    = 1'b0;
    h_sel   = sel;
    h_addr  = addr;
    applyStimulus();
    h_valid = 1'b0;
    #1;
    checkOutput({tag, "Valid"}, 32'(h_rvalid), 32'd1);
    checkOutput(tag, h_rdata, exp);
  endtask

  task automatic goHalt(input string tag);
    run_req = 1'b0;
    idleInputs();
    for (int i = 0; i < 8 && mState != M_HALT; i++) applyStimulus();
    #1;
    checkOutput(tag, 32'(h_ready), 32'd1);
  endtask

  logic [10:0] initAddr;
  logic [31:0] imemVals [4];

  initial begin
    checks     = 0;
    failures   = 0;
    mKnown     = 1'b0;
    mState     = M_HALT;
    mDrainLeft = 0;
    imemVals   = '{32'h11, 32'h22, 32'h33, 32'h44};
    rst_n   = 1'b0;
    run_req = 1'b0;
    I_ADDR  = '0;
    D_ADDR  = '0;
    D_OUT   = '0;
    h_sel   = '0;
    h_addr  = '0;
    h_wdata = '0;
    idleInputs();
    @(negedge clk);
    applyStimulus();
    applyStimulus();
    rst_n = 1'b1;
    #1;
    checkOutput("resetCpuRstN", 32'(cpu_rst_n), 32'd0);
    checkOutput("resetHready", 32'(h_ready), 32'd1);
    checkOutput("resetDIn", D_IN, 32'd0);

    // Fill the address pool used by random traffic, including the top words.
    for (int a = 0; a < 24; a++) begin
      initAddr = (a < 16) ? 11'(a) : 11'(2040 + a - 16);
      hostWrite(2'd0, initAddr, $urandom);
      hostWrite(2'd1, initAddr, $urandom);
    end

    // Host load and dump of imem while halted.
    for (int i = 0; i < 4; i++) hostWrite(2'd0, 11'(i), imemVals[i]);
    for (int i = 0; i < 4; i++) hostRead("imemDump", 2'd0, 11'(i), imemVals[i]);
    checkOutput("haltCpuRstN", 32'(cpu_rst_n), 32'd0);

    // Load from host-written data.
    hostWrite(2'd1, 11'd5, 32'hDEADBEEF);
    run_req = 1'b1;
    applyStimulus();
    D_ADDR = 11'd5;
    dm_oen = 1'b0;
    applyStimulus();
    dm_oen = 1'b1;
    #1;
    checkOutput("loadData", D_IN, 32'hDEADBEEF);
    applyStimulus();
    #1;
    checkOutput("loadHold", D_IN, 32'hDEADBEEF);

    // Write-first when load and store coincide.
    D_ADDR = 11'd7;
    D_OUT  = 32'hA5A5A5A5;
    dm_wen = 1'b0;
    dm_oen = 1'b0;
    applyStimulus();
    idleInputs();
    #1;
    checkOutput("writeFirst", D_IN, 32'hA5A5A5A5);

    // Drain: two cycles still served, HALT on the third edge.
    run_req = 1'b0;
    applyStimulus();
    #1;
    checkOutput("drain1Hready", 32'(h_ready), 32'd0);
    checkOutput("drain1CpuRstN", 32'(cpu_rst_n), 32'd1);
    D_ADDR = 11'd9;
    D_OUT  = 32'h0BADF00D;
    dm_wen = 1'b0;
    applyStimulus();
    idleInputs();
    #1;
    checkOutput("drain2Hready", 32'(h_ready), 32'd0);
    applyStimulus();
    #1;
    checkOutput("drainHaltCpuRstN", 32'(cpu_rst_n), 32'd0);
    checkOutput("drainHaltHready", 32'(h_ready), 32'd1);
    hostRead("dumpDmem7", 2'd1, 11'd7, 32'hA5A5A5A5);
    hostRead("dumpDmem9", 2'd1, 11'd9, 32'h0BADF00D);

    // Re-asserting run_req during DRAIN returns to RUN without halting.
    run_req = 1'b1;
    applyStimulus();
    run_req = 1'b0;
    applyStimulus();
    run_req = 1'b1;
    #1;
    checkOutput("redrainCpuRstN", 32'(cpu_rst_n), 32'd1);
    applyStimulus();
    #1;
    checkOutput("rerunCpuRstN", 32'(cpu_rst_n), 32'd1);
    checkOutput("rerunRunning", 32'(running), 32'd1);
    goHalt("haltAfterRerun");

    // Counters: 10 RUN cycles fetching, three loads, then clear.
    hostWrite(2'd2, 11'd0, 32'd0);
    run_req = 1'b1;
    applyStimulus();
    for (int i = 0; i < 10; i++) begin
      im_oen  = 1'b0;
      I_ADDR  = 11'(i % 4);
      dm_oen  = (i < 3) ? 1'b0 : 1'b1;
      D_ADDR  = 11'd5;
      run_req = (i != 9);
      applyStimulus();
    end
    goHalt("haltAfterCount");
    hostRead("cntFetch", 2'd2, 11'd0, 32'd10);
    hostRead("cntLoad", 2'd2, 11'd1, 32'd3);
    hostRead("cntStore", 2'd2, 11'd2, 32'd0);
    hostRead("cntRun", 2'd2, 11'd3, 32'd10);
    hostRead("reservedRead", 2'd3, 11'd1, 32'd0);
    hostWrite(2'd2, 11'd2, 32'hFFFFFFFF);
    for (int i = 0; i < 4; i++) hostRead("cntCleared", 2'd2, 11'(i), 32'd0);

    // Randomized mixed traffic against the model.
    for (int cyc = 0; cyc < 1500; cyc++) begin
      if ($urandom_range(0, 7) == 0) run_req = ~run_req;
      if (mState != M_HALT) begin
        im_oen = 1'($urandom_range(0, 1));
        I_ADDR = pickAddr();
        dm_oen = 1'($urandom_range(0, 1));
        dm_wen = ($urandom_range(0, 2) != 0);
        D_ADDR = pickAddr();
        D_OUT  = $urandom;
      end else begin
        im_oen = 1'b1;
        dm_oen = 1'b1;
        dm_wen = 1'b1;
      end
      h_valid = 1'($urandom_range(0, 1));
      h_we    = 1'($urandom_range(0, 1));
      h_sel   = 2'($urandom_range(0, 3));
      h_addr  = h_sel[1] ? 11'($urandom) : pickAddr();
      h_wdata = $urandom;
      applyStimulus();
    end

    // Reset arriving the cycle after an accepted read drops that read.
    goHalt("haltBeforeReset");
    h_valid = 1'b1;
    h_we    = 1'b0;
    h_sel   = 2'd0;
    h_addr  = 11'd2;
    applyStimulus();
    idleInputs();
    rst_n = 1'b0;
    #1;
    checkOutput("resetDropsRvalid", 32'(h_rvalid), 32'd0);
    applyStimulus();
    rst_n = 1'b1;
    applyStimulus();
    #1;
    checkOutput("postResetRvalid", 32'(h_rvalid), 32'd0);
    checkOutput("postResetRunning", 32'(running), 32'd0);
    checkOutput("postResetCpuRstN", 32'(cpu_rst_n), 32'd0);
    for (int i = 0; i < 4; i++) hostRead("postResetCnt", 2'd2, 11'(i), 32'd0);
    for (int i = 0; i < 4; i++) hostRead("postResetImem", 2'd0, 11'(i), mImem[i]);
    hostRead("postResetDmemTop", 2'd1, 11'd2047, mDmem[2047]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
